// File: rtl/spi_shader_loader.sv
//------------------------------------------------------------------------------
// Module   : spi_shader_loader
// Purpose  : SPI slave (CPOL=0, CPHA=1, MSB first, 8-bit words) that loads
//            shader instruction bytes and a user register. All SPI inputs are
//            oversampled in the clk_i domain.
// Ports    : clk_i, rst_i            - system clock, sync active-high reset
//            spi_sclk_i/mosi_i/cs_ni - asynchronous SPI inputs
//            spi_miso_o              - readback data (0 unless SPI_READBACK_EN)
//            instr_o/instr_valid_o   - instruction byte + 1-cycle strobe
//            user_o/user_valid_o     - user register + 1-cycle update strobe
//            load_active_o           - high while in the LOAD state
// Config   : define SPI_READBACK_EN to shift the last completed byte out on MISO
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module spi_shader_loader #(
  parameter int SYNC_STAGES = 2,  // legal range 2..3
  parameter int NUM_INSTR   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_ni,
  output logic       spi_miso_o,
  output logic [7:0] instr_o,
  output logic       instr_valid_o,
  output logic [7:0] user_o,
  output logic       user_valid_o,
  output logic       load_active_o
);

  localparam int c_CNT_W = $clog2(NUM_INSTR + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_INSTR = c_CNT_W'(NUM_INSTR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_LOAD   = 3'd2,
    S_USER   = 3'd3,
    S_IGNORE = 3'd4
  } state_t;

  // Synchronizers plus one extra stage for edge detection
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_bitcnt;
  logic [6:0]           r_shift;
  logic [c_CNT_W-1:0]   r_icnt;
  logic [7:0]           r_instr;
  logic                 r_instr_valid;
  logic [7:0]           r_user;
  logic                 r_user_valid;

  logic       w_sclk_s;
  logic       w_mosi_s;
  logic       w_cs_s;
  logic       w_sclk_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_byte_done;
  logic [7:0] w_byte;
  logic       w_instr_emit;
  logic       w_user_emit;
  logic       w_cnt_clr;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

  // SCLK edges only count while CS is low; this also makes a CS rise win
  // over a byte completing in the same cycle.
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s & ~w_cs_s;
  assign w_cs_fall   = r_cs_d & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_d & w_cs_s;

  assign w_byte      = {r_shift, w_mosi_s};
  assign w_byte_done = w_sclk_fall && (r_bitcnt == 3'd7);

  //--------------------------------------------------------------------------
  // FSM state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM next-state and datapath controls
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_instr_emit = 1'b0;
    w_user_emit  = 1'b0;
    w_cnt_clr    = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            w_state_nxt = S_CMD;
            w_cnt_clr   = 1'b1;
          end
        end
        S_CMD: begin
          if (w_byte_done) begin
            case (w_byte)
              8'h00:   w_state_nxt = S_LOAD;
              8'h01:   w_state_nxt = S_USER;
              default: w_state_nxt = S_IGNORE;
            endcase
          end
        end
        S_LOAD: begin
          // Bytes beyond NUM_INSTR are silently dropped
          if (w_byte_done && (r_icnt < c_MAX_INSTR)) begin
            w_instr_emit = 1'b1;
          end
        end
        S_USER: begin
          if (w_byte_done) begin
            w_user_emit = 1'b1;
            w_state_nxt = S_IGNORE;
          end
        end
        S_IGNORE: begin
          w_state_nxt = S_IGNORE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Synchronizers, bit/instruction counters, shift register, output regs
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk_sync   <= '0;
      r_mosi_sync   <= '0;
      r_cs_sync     <= '0;
      r_sclk_d      <= 1'b0;
      r_cs_d        <= 1'b0;
      r_bitcnt      <= 3'd0;
      r_shift       <= 7'd0;
      r_icnt        <= '0;
      r_instr       <= 8'h00;
      r_instr_valid <= 1'b0;
      r_user        <= 8'h00;
      r_user_valid  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;

      // Clearing on CS edges discards any partial byte
      if (w_cnt_clr) begin
        r_bitcnt <= 3'd0;
        r_shift  <= 7'd0;
        r_icnt   <= '0;
      end else begin
        if (w_sclk_fall) begin
          r_shift  <= w_byte[6:0];
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        if (w_instr_emit) begin
          r_icnt <= r_icnt + c_CNT_W'(1);
        end
      end

      r_instr_valid <= w_instr_emit;
      if (w_instr_emit) begin
        r_instr <= w_byte;
      end
      r_user_valid <= w_user_emit;
      if (w_user_emit) begin
        r_user <= w_byte;
      end
    end
  end

  assign instr_o       = r_instr;
  assign instr_valid_o = r_instr_valid;
  assign user_o        = r_user;
  assign user_valid_o  = r_user_valid;
  assign load_active_o = (r_state == S_LOAD);

  //--------------------------------------------------------------------------
  // Optional MISO readback of the last completed byte
  //--------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
  logic [7:0] r_last;
  logic       r_miso;
  logic       w_sclk_rise;

  assign w_sclk_rise = ~r_sclk_d & w_sclk_s & ~w_cs_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 8'h00;
      r_miso <= 1'b0;
    end else begin
      if (w_byte_done && (r_state != S_IDLE)) begin
        r_last <= w_byte;
      end
      // On a rising edge the bit counter points at the bit about to be
      // sampled, so bit (7 - count) goes out MSB first.
      if (w_sclk_rise) begin
        r_miso <= r_last[3'd7 - r_bitcnt];
      end
    end
  end

  assign spi_miso_o = r_miso;
`else
  assign spi_miso_o = 1'b0;
`endif

endmodule

`default_nettype wire
